// File: rtl/round_module_if.sv
// Round data/key bus: the source drives the qualified round inputs, the
// round engine returns the registered key, state and qualifier.
interface round_module_if;
  logic [127:0] Input;
  logic [127:0] Key;
  logic [3:0]   Round_count;
  logic         In_valid;
  logic [127:0] output_key;
  logic [127:0] Output;
  logic         Out_valid;

  modport master (
    output Input, Key, Round_count, In_valid,
    input  output_key, Output, Out_valid
  );

  modport slave (
    input  Input, Key, Round_count, In_valid,
    output output_key, Output, Out_valid
  );
endinterface

// File: rtl/round_module.sv
// Single AES-128 encryption round with on-the-fly key expansion; one-cycle
// latency, one round per cycle. Rounds 11..15 pass data and key through.
module round_module (
  input  logic          CLK,
  input  logic          RST_N,
  round_module_if.slave bus
);

  // Forward S-box, byte 0x00 in the top byte, one row of 16 entries per line.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Byte 4c+r sits at row r, column c; ShiftRows pulls from column c+r.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [127:0] key_d, key_q;
  logic [127:0] data_d, data_q;
  logic         valid_q;
  logic [31:0]  rot_w, t_w, n0, n1, n2, n3;
  logic [127:0] next_key, sr_state;

  always_comb begin
    rot_w    = {bus.Key[23:0], bus.Key[31:24]};
    t_w      = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])}
               ^ {rcon(bus.Round_count), 24'h0};
    n0       = bus.Key[127:96] ^ t_w;
    n1       = bus.Key[95:64]  ^ n0;
    n2       = bus.Key[63:32]  ^ n1;
    n3       = bus.Key[31:0]   ^ n2;
    next_key = {n0, n1, n2, n3};
    sr_state = sub_shift(bus.Input);

    key_d  = bus.Key;
    data_d = bus.Input;
    if (bus.Round_count == 4'd0) begin
      data_d = bus.Input ^ bus.Key;
    end else if (bus.Round_count <= 4'd9) begin
      key_d  = next_key;
      data_d = mix_columns(sr_state) ^ next_key;
    end else if (bus.Round_count == 4'd10) begin
      key_d  = next_key;
      data_d = sr_state ^ next_key;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      key_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= bus.In_valid;
      if (bus.In_valid) begin
        key_q  <= key_d;
        data_q <= data_d;
      end
    end
  end

  assign bus.output_key = key_q;
  assign bus.Output     = data_q;
  assign bus.Out_valid  = valid_q;

endmodule

// File: tb/tb_round_module.sv
// Directed-vector bench for round_module using FIPS-197 round vectors.
module tb_round_module;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  round_module_if bus ();

  round_module dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  localparam logic [127:0] K_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IN_0  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] OUT_0 = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] K_1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] OUT_1 = 128'ha49c7ff2689f352b6b5bea43026a5049;

  task automatic drive(input logic [127:0] din, input logic [127:0] key,
                       input logic [3:0] rc, input logic vld);
    bus.Input       = din;
    bus.Key         = key;
    bus.Round_count = rc;
    bus.In_valid    = vld;
  endtask

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    drive(128'hffff_0000_1234_5678_9abc_def0_5555_aaaa, K_A, 4'd1, 1'b1);
    RST_N = 1'b0;
    #2;
    vectors++;
    if (bus.Output !== '0) begin
      miscompares++;
      $display("FAIL reset_output: got %h want 0", bus.Output);
    end
    vectors++;
    if (bus.output_key !== '0) begin
      miscompares++;
      $display("FAIL reset_key: got %h want 0", bus.output_key);
    end
    vectors++;
    if (bus.Out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid: got %b want 0", bus.Out_valid);
    end
    step();
    vectors++;
    if (bus.Out_valid !== 1'b0 || bus.Output !== '0) begin
      miscompares++;
      $display("FAIL reset_held: got valid=%b out=%h want 0/0", bus.Out_valid, bus.Output);
    end
    drive('0, '0, 4'd0, 1'b0);
    RST_N = 1'b1;
  endtask

  task automatic test_round1_zero_input;
    drive('0, 128'h000102030405060708090a0b0c0d0e0f, 4'd1, 1'b1);
    step();
    bus.In_valid = 1'b0;
    vectors++;
    if (bus.output_key !== 128'hd6aa74fdd2af72fadaa678f1d6ab76fe) begin
      miscompares++;
      $display("FAIL r1zero_key: got %h want d6aa74fdd2af72fadaa678f1d6ab76fe", bus.output_key);
    end
    vectors++;
    if (bus.Output !== 128'hb5c9179eb1cc1199b9c51b92b5c8159d) begin
      miscompares++;
      $display("FAIL r1zero_out: got %h want b5c9179eb1cc1199b9c51b92b5c8159d", bus.Output);
    end
    vectors++;
    if (bus.Out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL r1zero_valid: got %b want 1", bus.Out_valid);
    end
  endtask

  task automatic test_round10;
    drive(128'heb40f21e592e38848ba113e71bc342d2, 128'hac7766f319fadc2128d12941575c006e, 4'd10, 1'b1);
    step();
    bus.In_valid = 1'b0;
    vectors++;
    if (bus.output_key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      miscompares++;
      $display("FAIL r10_key: got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", bus.output_key);
    end
    vectors++;
    if (bus.Output !== 128'h3925841d02dc09fbdc118597196a0b32) begin
      miscompares++;
      $display("FAIL r10_out: got %h want 3925841d02dc09fbdc118597196a0b32", bus.Output);
    end
  endtask

  task automatic test_passthrough;
    drive(128'h0123456789abcdef_fedcba9876543210, K_A, 4'd11, 1'b1);
    step();
    vectors++;
    if (bus.Output !== 128'h0123456789abcdef_fedcba9876543210 || bus.output_key !== K_A
        || bus.Out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL pass11: got out=%h key=%h v=%b want out=0123456789abcdeffedcba9876543210 key=%h v=1",
               bus.Output, bus.output_key, bus.Out_valid, K_A);
    end
    drive(128'h55aa55aa_11223344_deadbeef_00000001, 128'h1, 4'd15, 1'b1);
    step();
    bus.In_valid = 1'b0;
    vectors++;
    if (bus.Output !== 128'h55aa55aa_11223344_deadbeef_00000001 || bus.output_key !== 128'h1) begin
      miscompares++;
      $display("FAIL pass15: got out=%h key=%h want out=55aa55aa11223344deadbeef00000001 key=1",
               bus.Output, bus.output_key);
    end
  endtask

  task automatic test_back_to_back;
    drive(IN_0, K_A, 4'd0, 1'b1);
    step();
    drive(OUT_0, K_A, 4'd1, 1'b1);
    vectors++;
    if (bus.Output !== OUT_0 || bus.output_key !== K_A || bus.Out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_r0: got out=%h key=%h v=%b want out=%h key=%h v=1",
               bus.Output, bus.output_key, bus.Out_valid, OUT_0, K_A);
    end
    step();
    drive(128'hdeadbeef_deadbeef_deadbeef_deadbeef, 128'hcafe, 4'd3, 1'b0);
    vectors++;
    if (bus.Output !== OUT_1 || bus.output_key !== K_1 || bus.Out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_r1: got out=%h key=%h v=%b want out=%h key=%h v=1",
               bus.Output, bus.output_key, bus.Out_valid, OUT_1, K_1);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (bus.Output !== OUT_1 || bus.output_key !== K_1 || bus.Out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_hold%0d: got out=%h key=%h v=%b want out=%h key=%h v=0",
                 i, bus.Output, bus.output_key, bus.Out_valid, OUT_1, K_1);
      end
    end
  endtask

  task automatic test_midstream_reset;
    drive(IN_0, K_A, 4'd0, 1'b1);
    step();
    drive(OUT_0, K_A, 4'd1, 1'b1);
    #2;
    RST_N = 1'b0;
    #1;
    vectors++;
    if (bus.Output !== '0 || bus.output_key !== '0 || bus.Out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_async: got out=%h key=%h v=%b want 0/0/0",
               bus.Output, bus.output_key, bus.Out_valid);
    end
    step();
    RST_N = 1'b1;
    bus.In_valid = 1'b0;
    step();
    vectors++;
    if (bus.Output !== '0 || bus.Out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_discard: got out=%h v=%b want 0/0", bus.Output, bus.Out_valid);
    end
    drive(IN_0, K_A, 4'd0, 1'b1);
    step();
    bus.In_valid = 1'b0;
    vectors++;
    if (bus.Output !== OUT_0 || bus.Out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_first: got out=%h v=%b want %h/1", bus.Output, bus.Out_valid, OUT_0);
    end
  endtask

  initial begin
    test_reset();
    step();
    test_round1_zero_input();
    test_round10();
    test_passthrough();
    test_back_to_back();
    test_midstream_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/round_module.md
ROUND_MODULE -- requirements
Module: round_module

Interface
REQ-001 The clock SHALL be CLK, input, 1 bit; all state updates on its rising edge.
REQ-002 The reset SHALL be RST_N, input, 1 bit, asynchronous and active-low.
REQ-003 The round-data input SHALL be Input, input, 128 bits: the AES state entering the round.
REQ-004 The cipher-key input SHALL be Key, input, 128 bits: the round key of the previous round.
REQ-005 The round-number input SHALL be Round_count, input, 4 bits, selecting round 0..10.
REQ-006 The input-qualifier SHALL be In_valid, input, 1 bit: Input, Key and Round_count are sampled when 1.
REQ-007 The key output SHALL be output_key, output, 128 bits, registered: the round key generated for this round.
REQ-008 The data output SHALL be Output, output, 128 bits, registered: the AES state leaving the round.
REQ-009 The output-qualifier SHALL be Out_valid, output, 1 bit, registered.

Function
REQ-010 Byte order SHALL be FIPS-197 column-major: bits 127:120 = byte 0 (row 0, col 0), bits 7:0 = byte 15 (row 3, col 3); words w0 = bits 127:96 .. w3 = bits 31:0.
REQ-011 Key expansion SHALL be AES-128: t = SubWord(RotWord(Key.w3)) xor {Rcon[r],24'h0}; n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
REQ-012 Rcon for r = 1..10 SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-013 Round 0 SHALL produce output_key = Key and Output = Input xor Key (initial AddRoundKey).
REQ-014 Rounds 1..9 SHALL produce Output = MixColumns(ShiftRows(SubBytes(Input))) xor output_key.
REQ-015 Round 10 SHALL omit MixColumns: Output = ShiftRows(SubBytes(Input)) xor output_key.
REQ-016 Round_count 11..15 SHALL produce output_key = Key and Output = Input (pass-through).
REQ-017 SubBytes SHALL use the standard AES forward S-box; MixColumns SHALL use GF(2^8) polynomial 0x11B with matrix rows {02 03 01 01} rotated.
REQ-018 ShiftRows SHALL rotate row r left by r bytes.
REQ-019 Latency SHALL be exactly 1 cycle: when In_valid = 1 at edge k, results appear and Out_valid = 1 after edge k.
REQ-020 When In_valid = 0 at an edge, Output and output_key SHALL hold their values and Out_valid SHALL be 0.
REQ-021 Back-to-back In_valid cycles SHALL be accepted every cycle with no stall (full throughput).

Reset
REQ-022 RST_N = 0 SHALL immediately, without waiting for CLK, force Output = 0, output_key = 0 and Out_valid = 0.
REQ-023 Reset asserted mid-stream SHALL discard the in-flight result; the first valid output after release is from the first In_valid sampled after release.

Verification
REQ-024 Reset: drive RST_N low with nonzero inputs -> Output = 0, output_key = 0, Out_valid = 0 before any clock edge.
REQ-025 Round 1, Key = 000102030405060708090A0B0C0D0E0F, Input = 0 -> output_key = D6AA74FDD2AF72FADAA678F1D6AB76FE, Output = B5C9179EB1CC1199B9C51B92B5C8159D, one cycle later.
REQ-026 Round 0, Input = 3243F6A8885A308D313198A2E0370734, Key = 2B7E151628AED2A6ABF7158809CF4F3C -> Output = 193DE3BEA0F4E22B9AC68D2AE9F84808, output_key = Key.
REQ-027 Round 1, Input = 193DE3BEA0F4E22B9AC68D2AE9F84808, Key = 2B7E151628AED2A6ABF7158809CF4F3C -> output_key = A0FAFE1788542CB123A339392A6C7605, Output = A49C7FF2689F352B6B5BEA43026A5049.
REQ-028 Round 10, Input = EB40F21E592E38848BA113E71BC342D2, Key = AC7766F319FADC2128D12941575C006E -> output_key = D014F9A8C9EE2589E13F0CC8B6630CA6, Output = 3925841D02DC09FBDC118597196A0B32.
REQ-029 Back-to-back REQ-026 then REQ-027 vectors followed by In_valid = 0 -> results on consecutive cycles, then outputs held with Out_valid = 0.
